// File: rtl/modbus_rtu_pkg.sv
// Shared Modbus RTU definitions: receiver FSM encoding, parity modes,
// bit-timing derivation and the parity helper.
package modbus_rtu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } rx_fsm_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   function automatic int bps_param(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   function automatic int half_bit(input int bps);
      return bps / 2;
   endfunction

   // Expected parity bit for a data byte under the given mode.
   function automatic logic expected_parity(input logic [7:0] data, input int mode);
      logic p;
      p = ^data;
      if (mode == PARITY_ODD) begin
         return ~p;
      end else begin
         return p;
      end
   endfunction

endpackage

// File: rtl/modbus_sync_edge.sv
// Two-flop synchronizer for the RX pin plus a falling-edge detector;
// all stages reset high so an idle line never produces a false edge.
module modbus_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic fall
);

   logic meta_r;
   logic sync_r;
   logic prev_r;

   // Synchronizer chain and edge-history register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_r <= 1'b1;
         sync_r <= 1'b1;
         prev_r <= 1'b1;
      end else begin
         meta_r <= din;
         sync_r <= meta_r;
         prev_r <= sync_r;
      end
   end

   assign dout = sync_r;
   assign fall = prev_r & ~sync_r;

endmodule

// File: rtl/modbus_uart_byte_rx.sv
// Modbus RTU UART byte receiver: mid-bit sampling, LSB-first data,
// optional parity, stop-bit check and break handling.
module modbus_uart_byte_rx
   import modbus_rtu_pkg::*;
#(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 9600,
   parameter int PARITY    = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_pin,
   output logic [7:0] rx_data,
   output logic       rx_done,
   output logic       rx_state,
   output logic       parity_err,
   output logic       frame_err
);

   localparam int BPS_PARAM = bps_param(CLK_FREQ, BAUD_RATE);
   localparam int HALF      = half_bit(BPS_PARAM);
   localparam int CNT_W     = (BPS_PARAM > 1) ? $clog2(BPS_PARAM) : 1;
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BPS_PARAM - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);

   generate
      if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
         $error("modbus_uart_byte_rx: PARITY must be 0, 1 or 2");
      end
   endgenerate

   logic             line_s;
   logic             fall_s;
   logic             sample_s;
   rx_fsm_e          state_r;
   rx_fsm_e          state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [2:0]       bit_idx_r;
   logic [7:0]       shift_r;
   logic             par_bad_r;
   logic [7:0]       rx_data_r,    rx_data_s;
   logic             rx_done_r,    rx_done_s;
   logic             rx_state_r,   rx_state_s;
   logic             parity_err_r, parity_err_s;
   logic             frame_err_r,  frame_err_s;

   modbus_sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (rx_pin),
      .dout (line_s),
      .fall (fall_s)
   );

   assign sample_s = (cnt_r == CNT_HALF);

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (fall_s) state_s = ST_START;
            else        state_s = ST_IDLE;
         end
         ST_START: begin
            if (sample_s) state_s = line_s ? ST_IDLE : ST_DATA;
            else          state_s = ST_START;
         end
         ST_DATA: begin
            if (sample_s && bit_idx_r == 3'd7)
               state_s = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            else
               state_s = ST_DATA;
         end
         ST_PARITY: begin
            if (sample_s) state_s = ST_STOP;
            else          state_s = ST_PARITY;
         end
         ST_STOP: begin
            if (sample_s) state_s = line_s ? ST_IDLE : ST_BREAK;
            else          state_s = ST_STOP;
         end
         ST_BREAK: begin
            if (line_s) state_s = ST_IDLE;
            else        state_s = ST_BREAK;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs; busy follows the next state so
   // it drops on the same edge as rx_done.
   always_comb begin
      rx_done_s    = 1'b0;
      rx_data_s    = rx_data_r;
      parity_err_s = parity_err_r;
      frame_err_s  = frame_err_r;
      case (state_s)
         ST_START, ST_DATA, ST_PARITY, ST_STOP: rx_state_s = 1'b1;
         default:                               rx_state_s = 1'b0;
      endcase
      if (state_r == ST_STOP && sample_s) begin
         rx_done_s    = 1'b1;
         rx_data_s    = shift_r;
         frame_err_s  = ~line_s;
         parity_err_s = (PARITY != PARITY_NONE) ? par_bad_r : 1'b0;
      end else begin
         rx_done_s = 1'b0;
      end
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data_r    <= 8'h00;
         rx_done_r    <= 1'b0;
         rx_state_r   <= 1'b0;
         parity_err_r <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         rx_data_r    <= rx_data_s;
         rx_done_r    <= rx_done_s;
         rx_state_r   <= rx_state_s;
         parity_err_r <= parity_err_s;
         frame_err_r  <= frame_err_s;
      end
   end

   // Bit timer (the detection cycle counts as 0), bit index, shifter, parity check.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r     <= CNT_ZERO;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'h00;
         par_bad_r <= 1'b0;
      end else begin
         if (state_r == ST_IDLE)       cnt_r <= fall_s ? CNT_ONE : CNT_ZERO;
         else if (state_r == ST_BREAK) cnt_r <= CNT_ZERO;
         else if (cnt_r == CNT_MAX)    cnt_r <= CNT_ZERO;
         else                          cnt_r <= cnt_r + CNT_ONE;

         if (state_r == ST_START) begin
            bit_idx_r <= 3'd0;
            par_bad_r <= 1'b0;
         end else if (state_r == ST_DATA && sample_s) begin
            bit_idx_r <= bit_idx_r + 3'd1;
            shift_r   <= {line_s, shift_r[7:1]};
         end else if (state_r == ST_PARITY && sample_s) begin
            par_bad_r <= (line_s != expected_parity(shift_r, PARITY));
         end
      end
   end

   assign rx_data    = rx_data_r;
   assign rx_done    = rx_done_r;
   assign rx_state   = rx_state_r;
   assign parity_err = parity_err_r;
   assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_modbus_uart_byte_rx.sv
// Scoreboard bench: instance 0 is 8N1, instance 1 is 8E1; both use 16-clock bits.
module tb_modbus_uart_byte_rx;
   import modbus_rtu_pkg::*;

   localparam int CLK_HALF = 5000;
   localparam int CLK_T    = 2 * CLK_HALF;
   localparam int BIT_T    = 16 * CLK_T;
   localparam int SLOW_T   = 163200;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_pin     [2];
   logic [7:0] rx_data    [2];
   logic       rx_done    [2];
   logic       rx_state   [2];
   logic       parity_err [2];
   logic       frame_err  [2];

   exp_t    expq [2][$];
   int      n_cmp = 0;
   int      n_err = 0;
   longint  rise_t [2];
   longint  done_t [2];
   int      rises  [2] = '{0, 0};
   logic    prev_state [2] = '{1'b0, 1'b0};
   logic    prev_done  [2] = '{1'b0, 1'b0};
   longint  t0;

   always #CLK_HALF clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      modbus_uart_byte_rx #(
         .CLK_FREQ  (160),
         .BAUD_RATE (10),
         .PARITY    ((g == 0) ? PARITY_NONE : PARITY_EVEN)
      ) dut (
         .clk        (clk),
         .rst        (rst),
         .rx_pin     (rx_pin[g]),
         .rx_data    (rx_data[g]),
         .rx_done    (rx_done[g]),
         .rx_state   (rx_state[g]),
         .parity_err (parity_err[g]),
         .frame_err  (frame_err[g])
      );
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: parity error when the sent parity bit disagrees with the
   // even-parity rule, framing error when the stop bit was sent low.
   task automatic push_exp(input int d, input logic [7:0] data, input logic use_par,
                           input logic par_bit, input logic stop_bit);
      exp_t e;
      e.data = data;
      e.perr = use_par && (par_bit != (($countones(data) % 2) == 1));
      e.ferr = !stop_bit;
      expq[d].push_back(e);
   endtask

   task automatic send_char(input int d, input logic [7:0] data, input logic use_par,
                            input logic par_bit, input logic stop_bit, input int bt);
      rx_pin[d] = 1'b0;
      #(bt);
      for (int i = 0; i < 8; i++) begin
         rx_pin[d] = data[i];
         #(bt);
      end
      if (use_par) begin
         rx_pin[d] = par_bit;
         #(bt);
      end
      rx_pin[d] = stop_bit;
      #(bt);
   endtask

   task automatic send_exp(input int d, input logic [7:0] data, input logic par_bit,
                           input logic stop_bit, input int bt);
      push_exp(d, data, (d == 1), par_bit, stop_bit);
      send_char(d, data, (d == 1), par_bit, stop_bit, bt);
   endtask

   // Monitor: pops the scoreboard on every rx_done and tracks busy timing.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            prev_state[d] = 1'b0;
            prev_done[d]  = 1'b0;
         end else begin
            if (rx_done[d]) begin
               done_t[d] = $time;
               chk("done_width", prev_done[d], 0);
               chk("busy_low_at_done", rx_state[d], 0);
               chk("busy_high_before_done", prev_state[d], 1);
               if (expq[d].size() == 0) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  exp_t e;
                  e = expq[d].pop_front();
                  chk("rx_data", rx_data[d], e.data);
                  chk("parity_err", parity_err[d], e.perr);
                  chk("frame_err", frame_err[d], e.ferr);
               end
            end
            if (rx_state[d] && !prev_state[d]) begin
               rise_t[d] = $time;
               rises[d]++;
            end
            prev_state[d] = rx_state[d];
            prev_done[d]  = rx_done[d];
         end
      end
   end

   task automatic chk_reset_outputs(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk({tag, "_rx_data"}, rx_data[d], 0);
         chk({tag, "_rx_done"}, rx_done[d], 0);
         chk({tag, "_rx_state"}, rx_state[d], 0);
         chk({tag, "_parity_err"}, parity_err[d], 0);
         chk({tag, "_frame_err"}, frame_err[d], 0);
      end
   endtask

   initial begin
      int rb;
      logic [7:0] b;
      rst = 1'b1;
      rx_pin[0] = 1'b1;
      rx_pin[1] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      #(2 * BIT_T);

      // 8N1 0xA5 with exact latency checks against the start edge.
      @(posedge clk);
      t0 = $time;
      #1;
      send_exp(0, 8'hA5, 1'b0, 1'b1, BIT_T);
      chk("busy_rise_time", rise_t[0] - t0, 3 * CLK_T + CLK_HALF);
      chk("done_time", done_t[0] - t0, (3 + 8 + 9 * 16) * CLK_T + CLK_HALF);
      #(2 * BIT_T);

      // Short low glitch: busy pulses, no character.
      rb = rises[0];
      rx_pin[0] = 1'b0;
      #(5 * CLK_T);
      rx_pin[0] = 1'b1;
      #(2 * BIT_T);
      chk("glitch_busy_pulse", rises[0], rb + 1);
      chk("glitch_busy_idle", rx_state[0], 0);

      // Even parity: wrong then correct parity bit.
      send_exp(1, 8'h03, 1'b1, 1'b1, BIT_T);
      #(BIT_T);
      send_exp(1, 8'h07, 1'b1, 1'b1, BIT_T);
      #(2 * BIT_T);

      // Low stop bit followed by a 5-bit break, then a clean 0x55.
      b = 8'($urandom);
      send_exp(0, b, 1'b0, 1'b0, BIT_T);
      rb = rises[0];
      #(5 * BIT_T);
      rx_pin[0] = 1'b1;
      #(2 * BIT_T);
      chk("break_no_busy", rises[0], rb);
      send_exp(0, 8'h55, 1'b0, 1'b1, BIT_T);
      #(2 * BIT_T);

      // Back-to-back characters from a 2% slow transmitter.
      rb = rises[0];
      send_exp(0, 8'h01, 1'b0, 1'b1, SLOW_T);
      send_exp(0, 8'hFE, 1'b0, 1'b1, SLOW_T);
      #(2 * BIT_T);
      chk("b2b_two_busy_periods", rises[0], rb + 2);

      // Reset in the middle of data bit 4 abandons the character.
      b = 8'($urandom);
      rx_pin[0] = 1'b0;
      #(BIT_T);
      for (int i = 0; i < 4; i++) begin
         rx_pin[0] = b[i];
         #(BIT_T);
      end
      rx_pin[0] = b[4];
      #(BIT_T / 2 + 2300);
      rst = 1'b1;
      #1;
      chk_reset_outputs("midchar_reset");
      rx_pin[0] = 1'b1;
      #(3 * CLK_T);
      rst = 1'b0;
      #(2 * BIT_T);
      send_exp(0, 8'h3C, 1'b0, 1'b1, BIT_T);
      #(BIT_T);

      // Randomized traffic on both instances.
      for (int k = 0; k < 8; k++) begin
         for (int d = 0; d < 2; d++) begin
            send_exp(d, 8'($urandom), 1'($urandom_range(0, 1)), 1'b1, BIT_T);
            #(BIT_T * $urandom_range(0, 2));
         end
      end

      #(3 * BIT_T);
      chk("scoreboard_empty_0", expq[0].size(), 0);
      chk("scoreboard_empty_1", expq[1].size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
